// File: rtl/sram_scan_ctrl_p.sv
// Bit-serial scan controller that loads or dumps a block of SRAM words.
// Frame format (LSB first): mode, count, start address, data; ends with an XOR checksum word.
module sram_scan_ctrl_p #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out,
    output logic              scan_out_vld,
    output logic              scan_busy,
    output logic              scan_done,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    localparam int MAX_W = (DATA_W > ADDR_W) ? ((DATA_W > CNT_W) ? DATA_W : CNT_W)
                                             : ((ADDR_W > CNT_W) ? ADDR_W : CNT_W);
    localparam int BIT_W = $clog2(MAX_W + 1);

    localparam logic [BIT_W-1:0]  CNT_LAST  = BIT_W'(CNT_W - 1);
    localparam logic [BIT_W-1:0]  ADDR_LAST = BIT_W'(ADDR_W - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [3:0] {
        H_MODE, H_CNT, H_ADDR, WR_SHIFT, RD_REQ, RD_WAIT, RD_SHIFT, CHK, DONE
    } state_t;

    state_t              state;
    logic                mode;
    logic [BIT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   chk;

    logic [CNT_W-1:0]    cnt_shift;
    logic [ADDR_W-1:0]   addr_shift;
    logic [DATA_W-1:0]   word_shift;

    assign cnt_shift  = {scan_in, cnt_reg[CNT_W-1:1]};
    assign addr_shift = {scan_in, addr_reg[ADDR_W-1:1]};
    assign word_shift = {scan_in, shreg[DATA_W-1:1]};
    assign scan_out   = shreg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= H_MODE;
            mode         <= 1'b0;
            bit_cnt      <= '0;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            shreg        <= '0;
            chk          <= '0;
            scan_out_vld <= 1'b0;
            scan_busy    <= 1'b0;
            scan_done    <= 1'b0;
            sram_en      <= 1'b0;
            sram_we      <= 1'b0;
            sram_addr    <= '0;
            sram_wdata   <= '0;
        end else begin
            sram_en <= 1'b0;
            case (state)
                H_MODE: if (scan_en) begin
                    mode      <= scan_in;
                    scan_busy <= 1'b1;
                    bit_cnt   <= '0;
                    state     <= H_CNT;
                end
                H_CNT: if (scan_en) begin
                    cnt_reg <= cnt_shift;
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                        state   <= H_ADDR;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_ONE;
                    end
                end
                H_ADDR: if (scan_en) begin
                    addr_reg <= addr_shift;
                    if (bit_cnt == ADDR_LAST) begin
                        bit_cnt <= '0;
                        if (mode) begin
                            state <= WR_SHIFT;
                        end else begin
                            state     <= RD_REQ;
                            sram_en   <= 1'b1;
                            sram_we   <= 1'b0;
                            sram_addr <= addr_shift;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_ONE;
                    end
                end
                // The commit is registered, so the next word keeps shifting in with no lost slot.
                WR_SHIFT: if (scan_en) begin
                    shreg <= word_shift;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt    <= '0;
                        sram_en    <= 1'b1;
                        sram_we    <= 1'b1;
                        sram_addr  <= addr_reg;
                        sram_wdata <= word_shift;
                        chk        <= chk ^ word_shift;
                        addr_reg   <= addr_reg + ADDR_ONE;
                        if (cnt_reg == '0) begin
                            state        <= CHK;
                            shreg        <= chk ^ word_shift;
                            scan_out_vld <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_ONE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_ONE;
                    end
                end
                // The SRAM handshake consumes no scan bits, so it runs even while scan_en is low.
                RD_REQ: state <= RD_WAIT;
                RD_WAIT: begin
                    shreg        <= sram_rdata;
                    chk          <= chk ^ sram_rdata;
                    scan_out_vld <= 1'b1;
                    bit_cnt      <= '0;
                    state        <= RD_SHIFT;
                end
                RD_SHIFT: if (scan_en) begin
                    shreg <= {1'b0, shreg[DATA_W-1:1]};
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt  <= '0;
                        addr_reg <= addr_reg + ADDR_ONE;
                        if (cnt_reg == '0) begin
                            state <= CHK;
                            shreg <= chk;
                        end else begin
                            cnt_reg      <= cnt_reg - CNT_ONE;
                            state        <= RD_REQ;
                            sram_en      <= 1'b1;
                            sram_we      <= 1'b0;
                            sram_addr    <= addr_reg + ADDR_ONE;
                            scan_out_vld <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_ONE;
                    end
                end
                CHK: if (scan_en) begin
                    shreg <= {1'b0, shreg[DATA_W-1:1]};
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt      <= '0;
                        state        <= DONE;
                        scan_out_vld <= 1'b0;
                        scan_busy    <= 1'b0;
                        scan_done    <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_ONE;
                    end
                end
                DONE: state <= DONE;
                default: state <= H_MODE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_scan_ctrl_p.sv
// Directed bench for sram_scan_ctrl_p: frame table on a 32/11/11 instance plus
// abort and small-parameter sequences on an 8/4/2 instance.
module tb_sram_scan_ctrl_p;
    localparam int DW = 32;
    localparam int AW = 11;
    localparam int CW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic          scan_en_a = 1'b0, scan_in_a = 1'b0;
    logic          scan_out_a, scan_out_vld_a, scan_busy_a, scan_done_a, sram_en_a, sram_we_a;
    logic [AW-1:0] sram_addr_a;
    logic [DW-1:0] sram_wdata_a;
    logic [DW-1:0] sram_rdata_a = '0;

    logic          scan_en_b = 1'b0, scan_in_b = 1'b0;
    logic          scan_out_b, scan_out_vld_b, scan_busy_b, scan_done_b, sram_en_b, sram_we_b;
    logic [3:0]    sram_addr_b;
    logic [7:0]    sram_wdata_b;
    logic [7:0]    sram_rdata_b = '0;

    sram_scan_ctrl_p #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .scan_en(scan_en_a), .scan_in(scan_in_a),
        .scan_out(scan_out_a), .scan_out_vld(scan_out_vld_a), .scan_busy(scan_busy_a),
        .scan_done(scan_done_a), .sram_en(sram_en_a), .sram_we(sram_we_a),
        .sram_addr(sram_addr_a), .sram_wdata(sram_wdata_a), .sram_rdata(sram_rdata_a)
    );

    sram_scan_ctrl_p #(.DATA_W(8), .ADDR_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .scan_en(scan_en_b), .scan_in(scan_in_b),
        .scan_out(scan_out_b), .scan_out_vld(scan_out_vld_b), .scan_busy(scan_busy_b),
        .scan_done(scan_done_b), .sram_en(sram_en_b), .sram_we(sram_we_b),
        .sram_addr(sram_addr_b), .sram_wdata(sram_wdata_b), .sram_rdata(sram_rdata_b)
    );

    // SRAM model for instance A: read data appears the cycle after the strobe
    logic [DW-1:0] mem [0:2047];
    always @(posedge clk) begin
        if (sram_en_a && sram_we_a) mem[sram_addr_a] <= sram_wdata_a;
        if (sram_en_a && !sram_we_a) sram_rdata_a <= mem[sram_addr_a];
    end

    logic        st_we[$];
    logic [31:0] st_addr[$];
    logic [31:0] st_data[$];
    logic [3:0]  b_addr[$];
    logic [7:0]  b_data[$];
    always @(negedge clk) begin
        if (sram_en_a) begin
            st_we.push_back(sram_we_a);
            st_addr.push_back(32'(sram_addr_a));
            st_data.push_back(sram_wdata_a);
        end
        if (sram_en_b && sram_we_b) begin
            b_addr.push_back(sram_addr_b);
            b_data.push_back(sram_wdata_b);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic             mode;
        logic             stall;
        logic [CW-1:0]    cnt;
        logic [AW-1:0]    addr;
        logic [3:0][31:0] words;
        logic [3:0][10:0] addrs;
        logic [31:0]      chk;
    } frame_t;

    function automatic frame_t mk(input logic mode, input logic stall, input logic [CW-1:0] cnt,
                                  input logic [AW-1:0] addr,
                                  input logic [31:0] w0, input logic [31:0] w1,
                                  input logic [31:0] w2, input logic [31:0] w3,
                                  input logic [10:0] a0, input logic [10:0] a1,
                                  input logic [10:0] a2, input logic [10:0] a3,
                                  input logic [31:0] chk);
        frame_t f;
        f.mode = mode; f.stall = stall; f.cnt = cnt; f.addr = addr; f.chk = chk;
        f.words[0] = w0; f.words[1] = w1; f.words[2] = w2; f.words[3] = w3;
        f.addrs[0] = a0; f.addrs[1] = a1; f.addrs[2] = a2; f.addrs[3] = a3;
        return f;
    endfunction

    // Serial position p of a frame: mode, count, address, then data words, all LSB first
    function automatic logic get_bit(input frame_t f, input int p);
        int h;
        h = 1 + CW + AW;
        if (p == 0) return f.mode;
        if (p < 1 + CW) return f.cnt[p-1];
        if (p < h) return f.addr[p-1-CW];
        return f.words[(p-h)/32][(p-h)%32];
    endfunction

    frame_t tbl[5];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; scan_en_a = 1'b0; scan_en_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_frame(input frame_t f, input int fi);
        int   hdr, total, nw, ptr, cyc, run, base, nout;
        logic en;
        logic outb[$];
        int   runs[$];
        logic [31:0] w;
        hdr   = 1 + CW + AW;
        nw    = int'(f.cnt) + 1;
        total = hdr + (f.mode ? nw * 32 : 0);
        base  = st_addr.size();
        ptr = 0; cyc = 0; run = 0;
        while (!scan_done_a && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (ptr >= hdr && !f.mode) begin
                if (!scan_out_vld_a) run++;
                else if (run > 0) begin runs.push_back(run); run = 0; end
            end
            en = f.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            scan_en_a = en;
            scan_in_a = (ptr < total) ? get_bit(f, ptr) : 1'($urandom_range(0, 1));
            if (en && ptr < total) ptr++;
            if (en && scan_out_vld_a) outb.push_back(scan_out_a);
        end
        scan_en_a = 1'b0;
        check($sformatf("f%0d_timeout", fi), 64'(cyc >= 3000), 64'd0);
        check($sformatf("f%0d_end_flags", fi), {scan_done_a, scan_busy_a, scan_out_vld_a}, 3'b100);
        check($sformatf("f%0d_strobes", fi), 64'(st_addr.size() - base), 64'(nw));
        for (int i = 0; i < nw && base + i < st_addr.size(); i++) begin
            check($sformatf("f%0d_we%0d", fi, i), st_we[base+i], f.mode);
            check($sformatf("f%0d_addr%0d", fi, i), st_addr[base+i], 32'(f.addrs[i]));
            if (f.mode) check($sformatf("f%0d_wdata%0d", fi, i), st_data[base+i], f.words[i]);
        end
        nout = f.mode ? 1 : nw + 1;
        check($sformatf("f%0d_outbits", fi), 64'(outb.size()), 64'(nout * 32));
        for (int j = 0; j < nout && (j + 1) * 32 <= outb.size(); j++) begin
            for (int k = 0; k < 32; k++) w[k] = outb[j*32+k];
            check($sformatf("f%0d_out%0d", fi, j), w, (j == nout - 1) ? f.chk : f.words[j]);
        end
        if (!f.mode) begin
            check($sformatf("f%0d_gaps", fi), 64'(runs.size()), 64'(nw));
            for (int i = 0; i < runs.size(); i++)
                check($sformatf("f%0d_gap%0d", fi, i), 64'(runs[i]), 64'd2);
        end
    endtask

    initial begin
        int base, cyc;
        logic [38:0] bv;
        logic [7:0]  bchk;
        int          bn;
        logic [3:0]  exp_ba [4];
        logic [7:0]  exp_bd [4];

        tbl[0] = mk(1'b1, 1'b0, 11'd3, 11'h000, 32'h00012117, 32'h04010113, 32'h00022517,
                    32'h03c50513, 11'h000, 11'h001, 11'h002, 11'h003, 32'h07C70000);
        tbl[1] = mk(1'b0, 1'b0, 11'd3, 11'h000, 32'h00012117, 32'h04010113, 32'h00022517,
                    32'h03c50513, 11'h000, 11'h001, 11'h002, 11'h003, 32'h07C70000);
        tbl[2] = mk(1'b1, 1'b0, 11'd1, 11'h7FF, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 32'h0,
                    11'h7FF, 11'h000, 11'h0, 11'h0, 32'hFFFFFFFF);
        tbl[3] = mk(1'b1, 1'b1, 11'd3, 11'h000, 32'h00012117, 32'h04010113, 32'h00022517,
                    32'h03c50513, 11'h000, 11'h001, 11'h002, 11'h003, 32'h07C70000);
        tbl[4] = mk(1'b0, 1'b0, 11'd1, 11'h7FF, 32'hA5A5A5A5, 32'h00012117, 32'h0, 32'h0,
                    11'h7FF, 11'h000, 11'h0, 11'h0, 32'hA5A484B2);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_outs_a", {scan_out_a, scan_out_vld_a, scan_busy_a, scan_done_a, sram_en_a,
                               sram_we_a, sram_addr_a, sram_wdata_a}, 64'd0);
        check("reset_outs_b", {scan_out_b, scan_out_vld_b, scan_busy_b, scan_done_b, sram_en_b,
                               sram_we_b, sram_addr_b, sram_wdata_b}, 64'd0);

        for (int fi = 0; fi < 5; fi++) begin
            do_reset();
            run_frame(tbl[fi], fi);
        end

        // Abort ten bits into the second data word
        do_reset();
        base = st_addr.size();
        for (int p = 0; p < 1 + CW + AW + 32 + 10; p++) begin
            @(negedge clk);
            scan_en_a = 1'b1;
            scan_in_a = get_bit(tbl[0], p);
        end
        @(negedge clk);
        check("abort_busy", scan_busy_a, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; scan_en_a = 1'b0;
        check("abort_outs", {scan_out_a, scan_out_vld_a, scan_busy_a, scan_done_a, sram_en_a,
                             sram_we_a, sram_addr_a, sram_wdata_a}, 64'd0);
        @(negedge clk);
        check("abort_no_strobe", sram_en_a, 1'b0);
        check("abort_strobes", 64'(st_addr.size() - base), 64'd1);
        if (st_addr.size() > base) begin
            check("abort_addr0", st_addr[base], 32'h0);
            check("abort_data0", st_data[base], 32'h00012117);
        end
        run_frame(tbl[0], 10);

        // Small-parameter instance: 4 words at E wrap to 1
        bv = {8'h71, 8'h0F, 8'hA5, 8'h3C, 4'hE, 2'b11, 1'b1};
        exp_ba = '{4'hE, 4'hF, 4'h0, 4'h1};
        exp_bd = '{8'h3C, 8'hA5, 8'h0F, 8'h71};
        do_reset();
        for (int p = 0; p < 39; p++) begin
            @(negedge clk);
            scan_en_b = 1'b1;
            scan_in_b = bv[p];
        end
        bn = 0; bchk = '0; cyc = 0;
        while (!scan_done_b && cyc < 200) begin
            @(negedge clk);
            cyc++;
            scan_en_b = 1'b1;
            scan_in_b = 1'b0;
            if (scan_out_vld_b) begin
                if (bn < 8) bchk[bn] = scan_out_b;
                bn++;
            end
        end
        scan_en_b = 1'b0;
        check("p_timeout", 64'(cyc >= 200), 64'd0);
        check("p_done", {scan_done_b, scan_busy_b}, 2'b10);
        check("p_chk_bits", 64'(bn), 64'd8);
        check("p_chk", bchk, 8'hE7);
        check("p_writes", 64'(b_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < b_addr.size(); i++) begin
            check($sformatf("p_addr%0d", i), b_addr[i], exp_ba[i]);
            check($sformatf("p_data%0d", i), b_data[i], exp_bd[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
